// File: rtl/pci_lite_target_pkg.sv
// Shared definitions for the PCI-lite target: bus commands, FSM encodings
// and byte-lane helpers.
package pci_lite_target_pkg;

   localparam logic [3:0] CMD_READ  = 4'b0110;
   localparam logic [3:0] CMD_WRITE = 4'b0111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_TURN = 2'd3;

   // Active-low byte enables to a 32-bit mask of lanes being written.
   function automatic logic [31:0] be_mask(input logic [3:0] be_n);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{~be_n[b]}};
      return m;
   endfunction

endpackage

// File: rtl/pci_lite_regfile.sv
// NREGS x 32 register file with active-low byte-enable writes, combinational
// read port and a flat export of every register.
module pci_lite_regfile
   import pci_lite_target_pkg::*;
#(
   parameter int IDX_W = 3
) (
   input  logic                         clk,
   input  logic                         rst_,
   input  logic                         we_i,
   input  logic [IDX_W-1:0]             widx_i,
   input  logic [3:0]                   be_n_i,
   input  logic [31:0]                  wdata_i,
   input  logic [IDX_W-1:0]             ridx_i,
   output logic [31:0]                  rdata_o,
   output logic [32*(2**IDX_W)-1:0]     regs_o
);

   localparam int NREGS = 2**IDX_W;

   logic [NREGS-1:0][31:0] regs_q;
   logic [31:0]            wmask;
   logic [31:0]            word_d;

   assign wmask  = be_mask(be_n_i);
   assign word_d = (regs_q[widx_i] & ~wmask) | (wdata_i & wmask);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)     regs_q         <= '0;
      else if (we_i) regs_q[widx_i] <= word_d;
   end

   assign rdata_o = regs_q[ridx_i];
   assign regs_o  = regs_q;

endmodule

// File: rtl/pci_lite_target.sv
// PCI-lite target: decodes address phases against a base window, claims with
// devsel_, inserts wait states, and completes data phases into a register file.
module pci_lite_target
   import pci_lite_target_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          IDX_W       = 3,
   parameter int          WAIT_STATES = 1
) (
   input  logic                         clk,
   input  logic                         rst_,
   input  logic                         frame_,
   input  logic                         irdy_,
   input  logic [31:0]                  ad_bus,
   input  logic [3:0]                   c_be_,
   output logic                         devsel_,
   output logic                         trdy_,
   output logic [31:0]                  rd_data,
   output logic [32*(2**IDX_W)-1:0]     regs_out,
   output logic                         wr_stb,
   output logic [IDX_W-1:0]             wr_idx
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             rw_q, rw_d;
   logic             frame_prev_q;
   logic [31:0]      rd_data_q, rd_data_d;
   logic             wr_stb_q, wr_stb_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;

   logic             hit, cmd_ok, start;
   logic [IDX_W-1:0] ad_idx, rd_idx;
   logic [31:0]      rf_rdata;
   logic             rf_we;
   logic             unused_ok;

   assign unused_ok = ^ad_bus[1:0];

   assign hit    = (ad_bus[31:IDX_W+2] == BASE_ADDR[31:IDX_W+2]);
   assign cmd_ok = (c_be_ == CMD_READ) || (c_be_ == CMD_WRITE);
   assign start  = !frame_ && frame_prev_q && hit && cmd_ok;
   assign ad_idx = ad_bus[IDX_W+1:2];

   // Read port follows whichever register rd_data is about to be loaded from.
   always_comb begin
      rd_idx = idx_q;
      if (state_q == ST_IDLE)      rd_idx = ad_idx;
      else if (state_q == ST_DATA) rd_idx = idx_q + 1'b1;
   end

   assign rf_we = (state_q == ST_DATA) && !irdy_ && rw_q;

   pci_lite_regfile #(.IDX_W(IDX_W)) u_regfile (
      .clk     (clk),
      .rst_    (rst_),
      .we_i    (rf_we),
      .widx_i  (idx_q),
      .be_n_i  (c_be_),
      .wdata_i (ad_bus),
      .ridx_i  (rd_idx),
      .rdata_o (rf_rdata),
      .regs_o  (regs_out)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rw_d      = rw_q;
      rd_data_d = rd_data_q;
      wr_stb_d  = 1'b0;
      wr_idx_d  = wr_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               idx_d = ad_idx;
               rw_d  = (c_be_ == CMD_WRITE);
               cnt_d = WS;
               if (WAIT_STATES == 0) begin
                  state_d = ST_DATA;
                  if (c_be_ == CMD_READ) rd_data_d = rf_rdata;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (frame_ && irdy_) begin
               state_d = ST_TURN;
            end else begin
               cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
               // Last wait cycle: present read data together with trdy_.
               if (cnt_q <= 4'd1) begin
                  state_d = ST_DATA;
                  if (!rw_q) rd_data_d = rf_rdata;
               end
            end
         end
         ST_DATA: begin
            if (!irdy_) begin
               wr_stb_d = rw_q;
               if (rw_q) wr_idx_d = idx_q;
               if (frame_) begin
                  state_d = ST_TURN;
               end else begin
                  idx_d = idx_q + 1'b1;
                  cnt_d = WS;
                  if (WAIT_STATES == 0) begin
                     if (!rw_q) rd_data_d = rf_rdata;
                  end else begin
                     state_d = ST_WAIT;
                  end
               end
            end else if (frame_) begin
               state_d = ST_TURN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         idx_q        <= '0;
         rw_q         <= 1'b0;
         frame_prev_q <= 1'b1;
         rd_data_q    <= '0;
         wr_stb_q     <= 1'b0;
         wr_idx_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         rw_q         <= rw_d;
         frame_prev_q <= frame_;
         rd_data_q    <= rd_data_d;
         wr_stb_q     <= wr_stb_d;
         wr_idx_q     <= wr_idx_d;
      end
   end

   assign devsel_ = !((state_q == ST_WAIT) || (state_q == ST_DATA));
   assign trdy_   = (state_q != ST_DATA);
   assign rd_data = rd_data_q;
   assign wr_stb  = wr_stb_q;
   assign wr_idx  = wr_idx_q;

endmodule

// File: tb/tb_pci_lite_target.sv
// Scoreboard bench for pci_lite_target: reads and write strobes are checked
// against queues filled when each phase is driven.
module tb_pci_lite_target;
   import pci_lite_target_pkg::*;

   localparam int IDX_W = 3;
   localparam int NREGS = 8;

   logic                   clk = 1'b0;
   logic                   rst_ = 1'b0;
   logic                   frame_ = 1'b1;
   logic                   irdy_ = 1'b1;
   logic [31:0]            ad_bus = '0;
   logic [3:0]             c_be_ = '0;

   logic                   devsel_, trdy_, wr_stb;
   logic [31:0]            rd_data;
   logic [32*NREGS-1:0]    regs_out;
   logic [IDX_W-1:0]       wr_idx;

   logic                   devsel0_, trdy0_, wr_stb0;
   logic [31:0]            rd_data0;
   logic [32*NREGS-1:0]    regs_out0;
   logic [IDX_W-1:0]       wr_idx0;

   logic                   devsel3_, trdy3_, wr_stb3;
   logic [31:0]            rd_data3;
   logic [32*NREGS-1:0]    regs_out3;
   logic [IDX_W-1:0]       wr_idx3;

   pci_lite_target #(.BASE_ADDR(32'h1000), .IDX_W(IDX_W), .WAIT_STATES(1)) dut (
      .clk(clk), .rst_(rst_), .frame_(frame_), .irdy_(irdy_), .ad_bus(ad_bus), .c_be_(c_be_),
      .devsel_(devsel_), .trdy_(trdy_), .rd_data(rd_data), .regs_out(regs_out),
      .wr_stb(wr_stb), .wr_idx(wr_idx));

   pci_lite_target #(.BASE_ADDR(32'h1000), .IDX_W(IDX_W), .WAIT_STATES(0)) dut_ws0 (
      .clk(clk), .rst_(rst_), .frame_(frame_), .irdy_(irdy_), .ad_bus(ad_bus), .c_be_(c_be_),
      .devsel_(devsel0_), .trdy_(trdy0_), .rd_data(rd_data0), .regs_out(regs_out0),
      .wr_stb(wr_stb0), .wr_idx(wr_idx0));

   pci_lite_target #(.BASE_ADDR(32'h1000), .IDX_W(IDX_W), .WAIT_STATES(3)) dut_ws3 (
      .clk(clk), .rst_(rst_), .frame_(frame_), .irdy_(irdy_), .ad_bus(ad_bus), .c_be_(c_be_),
      .devsel_(devsel3_), .trdy_(trdy3_), .rd_data(rd_data3), .regs_out(regs_out3),
      .wr_stb(wr_stb3), .wr_idx(wr_idx3));

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   logic [31:0] model [NREGS];
   logic [31:0] exp_rd [$];
   logic [31:0] exp_wr [$];
   bit          cur_rd = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_wr(input int k, input logic [31:0] d, input logic [3:0] be_n);
      for (int b = 0; b < 4; b++)
         if (!be_n[b]) model[k][8*b +: 8] = d[8*b +: 8];
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < NREGS; i++)
         chk($sformatf("%s_reg%0d", tag, i), regs_out[32*i +: 32], model[i]);
   endtask

   task automatic wait_trdy();
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         if (!trdy_) return;
         tick();
      end
      chk("trdy_timeout", 32'(trdy_), 32'd0);
   endtask

   task automatic burst(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                        input logic [31:0] wd [NREGS], input logic [3:0] be [NREGS],
                        input int stall_ph, input int stall_n);
      int          start;
      int          k;
      logic [31:0] hold;
      start  = int'(addr[IDX_W+1:2]);
      hold   = '0;
      cur_rd = (cmd == CMD_READ);
      frame_ = 1'b0; irdy_ = 1'b1; ad_bus = addr; c_be_ = cmd;
      tick();
      for (int p = 0; p < n; p++) begin
         k = (start + p) % NREGS;
         if (cmd == CMD_WRITE) begin
            model_wr(k, wd[p], be[p]);
            exp_wr.push_back(32'(k));
         end else begin
            exp_rd.push_back(model[k]);
         end
         ad_bus = wd[p]; c_be_ = be[p];
         if (p == stall_ph) begin
            frame_ = 1'b0; irdy_ = 1'b1;
            wait_trdy();
            hold = rd_data;
            for (int s = 1; s < stall_n; s++) begin
               tick();
               @(negedge clk);
               chk("stall_trdy", 32'(trdy_), 32'd0);
               chk("stall_rd_data", rd_data, hold);
            end
            tick();
         end
         frame_ = (p == n - 1); irdy_ = 1'b0;
         wait_trdy();
         if (p == stall_ph) chk("stall_rd_at_xfer", rd_data, hold);
         tick();
      end
      frame_ = 1'b1; irdy_ = 1'b1; ad_bus = '0; c_be_ = '0;
   endtask

   always @(negedge clk) begin
      if (rst_) begin
         if (cur_rd && !devsel_ && !trdy_ && !irdy_) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 32'(exp_rd.size()), 32'd1);
            else                    chk("rd_data", rd_data, exp_rd.pop_front());
         end
         if (wr_stb) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", 32'(exp_wr.size()), 32'd1);
            else                    chk("wr_idx", 32'(wr_idx), exp_wr.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] wd [NREGS];
      logic [3:0]  be [NREGS];
      int          first0, first3;

      for (int i = 0; i < NREGS; i++) begin
         model[i] = '0; wd[i] = '0; be[i] = 4'h0;
      end

      // reset state
      #2;
      chk("rst_devsel", 32'(devsel_), 32'd1);
      chk("rst_trdy", 32'(trdy_), 32'd1);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_wr_stb", 32'(wr_stb), 32'd0);
      chk("rst_wr_idx", 32'(wr_idx), 32'd0);
      check_regs("rst");
      #10 rst_ = 1'b1;
      tick();

      // single write with cycle-exact handshake
      cur_rd = 1'b0;
      frame_ = 1'b0; irdy_ = 1'b1; ad_bus = 32'h1008; c_be_ = CMD_WRITE;
      @(negedge clk);
      chk("sw_c0_devsel", 32'(devsel_), 32'd1);
      tick();
      frame_ = 1'b1; irdy_ = 1'b0; ad_bus = 32'hDEADBEEF; c_be_ = 4'b0000;
      model_wr(2, 32'hDEADBEEF, 4'b0000);
      exp_wr.push_back(32'd2);
      @(negedge clk);
      chk("sw_c1_devsel", 32'(devsel_), 32'd0);
      chk("sw_c1_trdy", 32'(trdy_), 32'd1);
      tick();
      @(negedge clk);
      chk("sw_c2_trdy", 32'(trdy_), 32'd0);
      chk("sw_c2_devsel", 32'(devsel_), 32'd0);
      tick();
      frame_ = 1'b1; irdy_ = 1'b1; ad_bus = '0;
      @(negedge clk);
      chk("sw_c3_turn_devsel", 32'(devsel_), 32'd1);
      chk("sw_c3_turn_trdy", 32'(trdy_), 32'd1);
      chk("sw_c3_wr_stb", 32'(wr_stb), 32'd1);
      tick();
      @(negedge clk);
      chk("sw_c4_wr_stb", 32'(wr_stb), 32'd0);
      check_regs("sw");
      tick();

      // byte-enable write, then all-ones enables (strobe but no change)
      wd[0] = 32'h11223344; be[0] = 4'b1010;
      burst(32'h1008, CMD_WRITE, 1, wd, be, -1, 0);
      tick();
      chk("be_reg2", regs_out[64 +: 32], 32'hDE22BE44);
      wd[0] = 32'hFFFFFFFF; be[0] = 4'b1111;
      burst(32'h1008, CMD_WRITE, 1, wd, be, -1, 0);
      tick(); tick();
      check_regs("be");

      // preload 0..7 with an 8-phase write burst
      for (int i = 0; i < NREGS; i++) begin wd[i] = 32'(i); be[i] = 4'h0; end
      burst(32'h1000, CMD_WRITE, NREGS, wd, be, -1, 0);
      tick(); tick();
      check_regs("pre");

      // read burst wrapping from index 7, stalled in the second phase
      burst(32'h101C, CMD_READ, 3, wd, be, 1, 2);
      tick(); tick();

      // miss and unsupported command
      cur_rd = 1'b0;
      frame_ = 1'b0; irdy_ = 1'b1; ad_bus = 32'h2000; c_be_ = CMD_READ;
      tick();
      frame_ = 1'b1; irdy_ = 1'b0; ad_bus = '0; c_be_ = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("miss_devsel", 32'(devsel_), 32'd1);
         chk("miss_trdy", 32'(trdy_), 32'd1);
         tick();
      end
      irdy_ = 1'b1;
      tick();
      frame_ = 1'b0; ad_bus = 32'h1000; c_be_ = 4'b0010;
      tick();
      frame_ = 1'b1; irdy_ = 1'b0; ad_bus = 32'h5555AAAA; c_be_ = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("badcmd_devsel", 32'(devsel_), 32'd1);
         chk("badcmd_trdy", 32'(trdy_), 32'd1);
         tick();
      end
      irdy_ = 1'b1; ad_bus = '0;
      tick();
      check_regs("miss");

      // wait-state latency: 0 vs 3 (the default instance also completes this read)
      cur_rd = 1'b1;
      exp_rd.push_back(model[1]);
      frame_ = 1'b0; irdy_ = 1'b1; ad_bus = 32'h1004; c_be_ = CMD_READ;
      tick();
      frame_ = 1'b1; irdy_ = 1'b0; ad_bus = '0; c_be_ = '0;
      first0 = -1; first3 = -1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (!trdy0_ && first0 < 0) first0 = c;
         if (!trdy3_ && first3 < 0) first3 = c;
         tick();
      end
      chk("ws0_trdy_cycle", 32'(first0), 32'd1);
      chk("ws3_trdy_cycle", 32'(first3), 32'd4);
      irdy_ = 1'b1;
      tick(); tick();

      // initiator abort during WAIT: no write, no strobe
      cur_rd = 1'b0;
      frame_ = 1'b0; irdy_ = 1'b1; ad_bus = 32'h1004; c_be_ = CMD_WRITE;
      tick();
      frame_ = 1'b1; irdy_ = 1'b1; ad_bus = 32'hFFFFFFFF; c_be_ = 4'b0000;
      @(negedge clk);
      chk("abort_wait_devsel", 32'(devsel_), 32'd0);
      tick();
      @(negedge clk);
      chk("abort_turn_devsel", 32'(devsel_), 32'd1);
      chk("abort_turn_trdy", 32'(trdy_), 32'd1);
      tick(); tick();
      ad_bus = '0;
      check_regs("abort");

      // async reset while stalled in DATA of a write
      frame_ = 1'b0; irdy_ = 1'b1; ad_bus = 32'h1008; c_be_ = CMD_WRITE;
      tick();
      ad_bus = 32'hCAFEF00D; c_be_ = 4'b0000;
      tick();
      @(negedge clk);
      chk("rst_mid_trdy_before", 32'(trdy_), 32'd0);
      #2 rst_ = 1'b0;
      #1;
      for (int i = 0; i < NREGS; i++) model[i] = '0;
      chk("rst_mid_devsel", 32'(devsel_), 32'd1);
      chk("rst_mid_trdy", 32'(trdy_), 32'd1);
      chk("rst_mid_rd_data", rd_data, 32'd0);
      chk("rst_mid_wr_stb", 32'(wr_stb), 32'd0);
      chk("rst_mid_wr_idx", 32'(wr_idx), 32'd0);
      check_regs("rst_mid");
      frame_ = 1'b1; irdy_ = 1'b1; ad_bus = '0; c_be_ = '0;
      #10 rst_ = 1'b1;
      tick(); tick();
      @(negedge clk);
      chk("post_rst_devsel", 32'(devsel_), 32'd1);

      chk("rd_queue_left", 32'(exp_rd.size()), 32'd0);
      chk("wr_queue_left", 32'(exp_wr.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
